pixel_pack_fifo: RTL and testbench

Parametrised write-side pixel packer and word buffer for the edge-detection AHB slave. It accepts N_CH processed pixels per `shift_enable` beat and packs them little-endian into BUS_W-bit words. Completed words are queued in a DEPTH-entry FIFO and presented show-ahead on `HWDATA` to the bus-side master logic. It adds back-pressure, a partial-word flush, and occupancy status.

---
 rtl/pixel_pack_pkg.sv | 21 ++
 rtl/pack_word_mem.sv | 40 ++++
 rtl/pixel_pack_fifo.sv | 162 ++++++++++++++++
 tb/tb_pixel_pack_fifo.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pack_pkg
//   Shared definitions for the pixel packer / word buffer of the edge-detection
//   AHB slave: default geometry constants, the beats-per-word helper and the
//   pixel type.
// -----------------------------------------------------------------------------
package pixel_pack_pkg;

  localparam int PIX_W_DFLT = 8;   // pixel width in bits
  localparam int N_CH_DFLT  = 2;   // pixels per input beat
  localparam int BUS_W_DFLT = 32;  // bus word width
  localparam int DEPTH_DFLT = 4;   // buffered words

  typedef logic [PIX_W_DFLT-1:0] pix_t;

  // Number of input beats that make one bus word.
  function automatic int beats_per_word(input int bus_w, input int beat_w);
    return bus_w / beat_w;
  endfunction

endpackage

// File: rtl/pack_word_mem.sv
// -----------------------------------------------------------------------------
// pack_word_mem
//   DEPTH x BUS_W word store for pixel_pack_fifo. One synchronous write port,
//   one asynchronous read port. The array has no reset: whether an entry holds
//   a valid word is tracked by the owner's occupancy count.
//
//   Ports
//     clk    : write clock (rising edge)
//     we     : write enable
//     waddr  : write address
//     wdata  : word to store
//     raddr  : read address
//     rdata  : word at raddr (combinational)
// -----------------------------------------------------------------------------
module pack_word_mem
  import pixel_pack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int BUS_W = BUS_W_DFLT,
  parameter int AW    = $clog2(DEPTH_DFLT)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [BUS_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_pack_fifo.sv
// -----------------------------------------------------------------------------
// pixel_pack_fifo
//   Write-side pixel packer and show-ahead word buffer. N_CH pixels arrive per
//   accepted beat and are packed little-endian (lane 0 = earliest pixel in the
//   lowest bits) into BUS_W-bit words. Completed words, or partial words closed
//   by flush (upper slices zero), are queued in a DEPTH-entry FIFO whose head
//   is presented on HWDATA.
//
//   Ports
//     HCLK         : clock, rising edge
//     HRESETn      : asynchronous active-low reset
//     shift_enable : input beat valid
//     data_out     : beat pixels, lane 0 in bits PIX_W-1:0
//     flush        : close the current partial word (may accompany a beat)
//     in_ready     : beat/flush accepted this cycle
//     HWDATA       : head word, zero when empty
//     wdata_valid  : FIFO non-empty
//     wdata_ready  : consumer pops the head word this cycle
//     count        : words stored
//     full, empty  : registered occupancy status
// -----------------------------------------------------------------------------
module pixel_pack_fifo
  import pixel_pack_pkg::*;
#(
  parameter int PIX_W = PIX_W_DFLT,
  parameter int N_CH  = N_CH_DFLT,
  parameter int BUS_W = BUS_W_DFLT,
  parameter int DEPTH = DEPTH_DFLT
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       shift_enable,
  input  logic [N_CH*PIX_W-1:0]      data_out,
  input  logic                       flush,
  output logic                       in_ready,
  output logic [BUS_W-1:0]           HWDATA,
  output logic                       wdata_valid,
  input  logic                       wdata_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int BEAT_W = N_CH * PIX_W;
  localparam int K      = beats_per_word(BUS_W, BEAT_W);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW     = (K > 1) ? $clog2(K) : 1;
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  if ((BUS_W % BEAT_W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("pixel_pack_fifo: BUS_W must be a multiple of N_CH*PIX_W and DEPTH a power of two >= 2");
  end

  // Packer state
  logic [BUS_W-1:0] acc;
  logic [IW-1:0]    idx;

  // FIFO state
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             full_q;
  logic             empty_q;

  logic             last_beat;
  logic             beat_take;
  logic             flush_take;
  logic             push;
  logic             pop;
  logic [BUS_W-1:0] word;
  logic [BUS_W-1:0] head;

  assign last_beat = (idx == IDX_LAST);

  // When full, only a beat that neither completes a word nor carries a flush
  // can be taken: it lands in acc without needing a FIFO slot. Depends on
  // registered full only, so wdata_ready never reaches in_ready.
  assign in_ready   = !full_q || (!last_beat && !flush);
  assign beat_take  = shift_enable && in_ready;
  assign flush_take = flush && in_ready;

  // A flush with nothing collected and no beat is accepted but pushes nothing.
  assign push = (beat_take && last_beat) ||
                (flush_take && ((idx != '0) || shift_enable));
  assign pop  = !empty_q && wdata_ready;

  // acc merged with the current beat; used both as the next acc and as the
  // word pushed, so the completing beat's pixels are part of the pushed word.
  always_comb begin
    word = acc;
    if (shift_enable) begin
      word[int'(idx) * BEAT_W +: BEAT_W] = data_out;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc <= '0;
      idx <= '0;
    end else if (push) begin
      acc <= '0;
      idx <= '0;
    end else if (beat_take) begin
      acc <= word;
      idx <= idx + IW'(1);
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits and wrap on their own.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt     <= cnt_next;
      full_q  <= (cnt_next == CNT_FULL);
      empty_q <= (cnt_next == '0);
    end
  end

  pack_word_mem #(
    .DEPTH (DEPTH),
    .BUS_W (BUS_W),
    .AW    (AW)
  ) u_mem (
    .clk   (HCLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (word),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Array contents are undefined until written, so gate the head with empty.
  assign HWDATA      = empty_q ? '0 : head;
  assign wdata_valid = !empty_q;
  assign count       = cnt;
  assign full        = full_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_pixel_pack_fifo
//   Three configurations of pixel_pack_fifo share one clock and reset:
//     cfg0: N_CH=2 (K=2), cfg1: N_CH=1 (K=4), cfg2: N_CH=4 (K=1); PIX_W=8,
//     BUS_W=32, DEPTH=4. Only the selected configuration sees live inputs.
//   The reference model keeps the pending pixels of the open word and the list
//   of stored words as queues.
// -----------------------------------------------------------------------------
module tb_pixel_pack_fifo;
  import pixel_pack_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        se, fl, rdy;
  logic [31:0] din;
  int          cur;

  logic        r0, v0, f0, e0, r1, v1, f1, e1, r2, v2, f2, e2;
  logic [31:0] h0, h1, h2;
  logic [2:0]  c0, c1, c2;

  pixel_pack_fifo #(.PIX_W(8), .N_CH(2), .BUS_W(32), .DEPTH(4)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .shift_enable(se && cur == 0), .data_out(din[15:0]),
    .flush(fl && cur == 0), .in_ready(r0), .HWDATA(h0), .wdata_valid(v0),
    .wdata_ready(rdy && cur == 0), .count(c0), .full(f0), .empty(e0));

  pixel_pack_fifo #(.PIX_W(8), .N_CH(1), .BUS_W(32), .DEPTH(4)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .shift_enable(se && cur == 1), .data_out(din[7:0]),
    .flush(fl && cur == 1), .in_ready(r1), .HWDATA(h1), .wdata_valid(v1),
    .wdata_ready(rdy && cur == 1), .count(c1), .full(f1), .empty(e1));

  pixel_pack_fifo #(.PIX_W(8), .N_CH(4), .BUS_W(32), .DEPTH(4)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .shift_enable(se && cur == 2), .data_out(din),
    .flush(fl && cur == 2), .in_ready(r2), .HWDATA(h2), .wdata_valid(v2),
    .wdata_ready(rdy && cur == 2), .count(c2), .full(f2), .empty(e2));

  logic        o_ready, o_valid, o_full, o_empty;
  logic [31:0] o_hwdata;
  logic [2:0]  o_count;

  always_comb begin
    o_ready = r0; o_valid = v0; o_full = f0; o_empty = e0; o_hwdata = h0; o_count = c0;
    if (cur == 1) begin
      o_ready = r1; o_valid = v1; o_full = f1; o_empty = e1; o_hwdata = h1; o_count = c1;
    end else if (cur == 2) begin
      o_ready = r2; o_valid = v2; o_full = f2; o_empty = e2; o_hwdata = h2; o_count = c2;
    end
  end

  int vectors = 0;
  int fails   = 0;

  // ---------------- reference model ----------------
  int          m_nch, m_k;
  logic [31:0] mq[$];
  pix_t        pend[$];
  logic        exp_ready, got_ready;

  task automatic m_reset(input int nch);
    m_nch = nch;
    m_k   = 4 / nch;
    mq.delete();
    pend.delete();
  endtask

  function automatic logic m_ready(input logic f);
    return (mq.size() < 4) || (((pend.size() / m_nch) < (m_k - 1)) && !f);
  endfunction

  function automatic logic [31:0] m_head();
    return (mq.size() != 0) ? mq[0] : 32'h0;
  endfunction

  task automatic m_update(input logic s, input logic f, input logic [31:0] d, input logic r);
    logic        do_pop, done;
    logic [31:0] w;
    do_pop = (mq.size() != 0) && r;
    done   = 1'b0;
    w      = 32'h0;
    if (m_ready(f)) begin
      if (s) for (int i = 0; i < m_nch; i++) pend.push_back(d[8*i +: 8]);
      if (pend.size() == 4 || (f && pend.size() != 0)) begin
        for (int i = 0; i < pend.size(); i++) w = w | (32'(pend[i]) << (8*i));
        pend.delete();
        done = 1'b1;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (done) mq.push_back(w);
  endtask

  // Beat b of word w for the current lane count.
  function automatic logic [31:0] slice_of(input logic [31:0] w, input int b);
    logic [31:0] m;
    m = (m_nch == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*m_nch)) - 32'd1);
    return (w >> (8*m_nch*b)) & m;
  endfunction

  // One clock: drive inputs, sample in_ready before the edge, update the model
  // at the edge, return 1 time unit after the edge.
  task automatic step(input logic s, input logic f, input logic [31:0] d, input logic r);
    se = s; fl = f; din = d; rdy = r;
    #1;
    exp_ready = m_ready(f);
    got_ready = o_ready;
    @(posedge clk);
    m_update(s, f, d, r);
    #1;
  endtask

  task automatic do_reset(input int which);
    se = 1'b0; fl = 1'b0; rdy = 1'b0; din = '0;
    cur   = which;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset(which == 0 ? 2 : (which == 1 ? 1 : 4));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset(input int which);
    do_reset(which);
    #1;
    vectors++; if (o_hwdata !== 32'h0) begin fails++; $display("FAIL reset_hwdata cfg%0d got %h want 0", cur, o_hwdata); end
    vectors++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cfg%0d got %b want 0", cur, o_valid); end
    vectors++; if (o_count !== 3'd0) begin fails++; $display("FAIL reset_count cfg%0d got %0d want 0", cur, o_count); end
    vectors++; if (o_full !== 1'b0) begin fails++; $display("FAIL reset_full cfg%0d got %b want 0", cur, o_full); end
    vectors++; if (o_empty !== 1'b1) begin fails++; $display("FAIL reset_empty cfg%0d got %b want 1", cur, o_empty); end
    vectors++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready cfg%0d got %b want 1", cur, o_ready); end
  endtask

  task automatic test_basic_pack(input int which);
    do_reset(which);
    for (int b = 0; b < m_k; b++) begin
      if (b == m_k - 1 && m_k > 1) begin
        vectors++; if (o_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid cfg%0d got %b want 0", cur, o_valid); end
      end
      step(1'b1, 1'b0, slice_of(32'h8564_3225, b), 1'b0);
    end
    vectors++; if (o_hwdata !== 32'h8564_3225) begin fails++; $display("FAIL basic_hwdata cfg%0d got %h want 85643225", cur, o_hwdata); end
    vectors++; if (o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid cfg%0d got %b want 1", cur, o_valid); end
    vectors++; if (o_count !== 3'd1) begin fails++; $display("FAIL basic_count cfg%0d got %0d want 1", cur, o_count); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++; if (o_hwdata !== 32'h0 || o_empty !== 1'b1) begin fails++; $display("FAIL basic_drain cfg%0d got %h/%b want 0/1", cur, o_hwdata, o_empty); end
  endtask

  task automatic test_flush(input int which);
    int nb;
    do_reset(which);
    nb = (2 + m_nch - 1) / m_nch;
    for (int b = 0; b < nb; b++) step(1'b1, 1'b0, slice_of(32'h0000_7910, b), 1'b0);
    if (m_k > 1) step(1'b0, 1'b1, 32'h0, 1'b0);
    vectors++; if (o_hwdata !== 32'h0000_7910) begin fails++; $display("FAIL flush_hwdata cfg%0d got %h want 00007910", cur, o_hwdata); end
    vectors++; if (o_count !== 3'd1) begin fails++; $display("FAIL flush_count cfg%0d got %0d want 1", cur, o_count); end
    // Flush with nothing pending: accepted, no effect.
    step(1'b0, 1'b1, 32'h0, 1'b0);
    vectors++; if (got_ready !== 1'b1) begin fails++; $display("FAIL noop_flush_ready cfg%0d got %b want 1", cur, got_ready); end
    vectors++; if (o_count !== 3'd1 || o_hwdata !== 32'h0000_7910) begin fails++; $display("FAIL noop_flush_state cfg%0d got %0d/%h want 1/00007910", cur, o_count, o_hwdata); end
    // A full word after the flush must start at lane 0 of a cleared word.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int b = 0; b < m_k; b++) step(1'b1, 1'b0, slice_of(32'h4433_2211, b), 1'b0);
    vectors++; if (o_hwdata !== 32'h4433_2211 || o_count !== 3'd1) begin fails++; $display("FAIL flush_idx_clear cfg%0d got %h/%0d want 44332211/1", cur, o_hwdata, o_count); end
  endtask

  task automatic test_fill_backpressure(input int which);
    logic [31:0] w [5];
    do_reset(which);
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < m_k; b++) step(1'b1, 1'b0, slice_of(w[i], b), 1'b0);
    vectors++; if (o_full !== 1'b1 || o_count !== 3'd4) begin fails++; $display("FAIL fill_full cfg%0d got %b/%0d want 1/4", cur, o_full, o_count); end
    vectors++; if (o_hwdata !== w[0]) begin fails++; $display("FAIL fill_head cfg%0d got %h want %h", cur, o_hwdata, w[0]); end
    // Non-completing beats of word 5 still enter the packer.
    for (int b = 0; b < m_k - 1; b++) begin
      step(1'b1, 1'b0, slice_of(w[4], b), 1'b0);
      vectors++; if (got_ready !== 1'b1 || o_count !== 3'd4) begin fails++; $display("FAIL fill_partial_accept cfg%0d got %b/%0d want 1/4", cur, got_ready, o_count); end
    end
    // Completing beat is held while full.
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b0, slice_of(w[4], m_k - 1), 1'b0);
      vectors++; if (got_ready !== 1'b0 || o_count !== 3'd4) begin fails++; $display("FAIL fill_hold cfg%0d got %b/%0d want 0/4", cur, got_ready, o_count); end
    end
    // Pop with the beat still held: slot not usable until next cycle.
    step(1'b1, 1'b0, slice_of(w[4], m_k - 1), 1'b1);
    vectors++; if (got_ready !== 1'b0) begin fails++; $display("FAIL fill_pop_ready cfg%0d got %b want 0", cur, got_ready); end
    vectors++; if (o_count !== 3'd3 || o_full !== 1'b0 || o_hwdata !== w[1]) begin fails++; $display("FAIL fill_after_pop cfg%0d got %0d/%b/%h want 3/0/%h", cur, o_count, o_full, o_hwdata, w[1]); end
    step(1'b1, 1'b0, slice_of(w[4], m_k - 1), 1'b0);
    vectors++; if (got_ready !== 1'b1 || o_count !== 3'd4 || o_full !== 1'b1) begin fails++; $display("FAIL fill_word5 cfg%0d got %b/%0d/%b want 1/4/1", cur, got_ready, o_count, o_full); end
    for (int i = 1; i < 5; i++) begin
      vectors++; if (o_hwdata !== w[i]) begin fails++; $display("FAIL fill_drain%0d cfg%0d got %h want %h", i, cur, o_hwdata, w[i]); end
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    vectors++; if (o_empty !== 1'b1 || o_hwdata !== 32'h0) begin fails++; $display("FAIL fill_empty cfg%0d got %b/%h want 1/0", cur, o_empty, o_hwdata); end
  endtask

  task automatic test_push_pop(input int which);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    do_reset(which);
    for (int i = 0; i < 2; i++) begin
      w = $urandom; exp_q.push_back(w);
      for (int b = 0; b < m_k; b++) step(1'b1, 1'b0, slice_of(w, b), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      for (int b = 0; b < m_k; b++) step(1'b1, 1'b0, slice_of(w, b), b == m_k - 1);
      void'(exp_q.pop_front());
      exp_q.push_back(w);
      vectors++; if (o_count !== 3'd2 || o_hwdata !== exp_q[0]) begin fails++; $display("FAIL pushpop%0d got %0d/%h want 2/%h", i, o_count, o_hwdata, exp_q[0]); end
    end
    while (exp_q.size() != 0) begin
      vectors++; if (o_hwdata !== exp_q[0]) begin fails++; $display("FAIL pushpop_drain got %h want %h", o_hwdata, exp_q[0]); end
      void'(exp_q.pop_front());
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    vectors++; if (o_empty !== 1'b1) begin fails++; $display("FAIL pushpop_empty got %b want 1", o_empty); end
  endtask

  task automatic test_reset_mid(input int which);
    do_reset(which);
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < m_k; b++) step(1'b1, 1'b0, slice_of($urandom, b), 1'b0);
    step(1'b1, 1'b0, 32'h0000_AAAA, 1'b0);
    se = 1'b0; fl = 1'b0; rdy = 1'b0;
    vectors++; if (o_count !== 3'd3) begin fails++; $display("FAIL midrst_setup got %0d want 3", o_count); end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (o_hwdata !== 32'h0 || o_valid !== 1'b0) begin fails++; $display("FAIL midrst_out got %h/%b want 0/0", o_hwdata, o_valid); end
    vectors++; if (o_count !== 3'd0 || o_full !== 1'b0 || o_empty !== 1'b1) begin fails++; $display("FAIL midrst_status got %0d/%b/%b want 0/0/1", o_count, o_full, o_empty); end
    vectors++; if (o_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b want 1", o_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset(m_nch);
    step(1'b1, 1'b0, 32'h0000_2211, 1'b0);
    step(1'b1, 1'b0, 32'h0000_4433, 1'b0);
    vectors++; if (o_hwdata !== 32'h4433_2211 || o_count !== 3'd1) begin fails++; $display("FAIL midrst_fresh got %h/%0d want 44332211/1", o_hwdata, o_count); end
  endtask

  task automatic test_random(input int which);
    logic        s, f, r, held;
    logic [31:0] d;
    int          rp;
    do_reset(which);
    s = 1'b0; f = 1'b0; d = '0; held = 1'b0; rp = 2;
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 0) rp = $urandom_range(0, 4);
      if (!held) begin
        s = ($urandom_range(0, 3) != 0);
        f = ($urandom_range(0, 7) == 0);
        d = $urandom;
      end
      r = ($urandom_range(0, 3) < rp);
      step(s, f, d, r);
      held = (s || f) && !exp_ready;
      vectors++; if (got_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready cfg%0d cyc%0d got %b want %b", cur, n, got_ready, exp_ready); end
      vectors++; if (o_hwdata !== m_head()) begin fails++; $display("FAIL rnd_hwdata cfg%0d cyc%0d got %h want %h", cur, n, o_hwdata, m_head()); end
      vectors++; if (o_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_valid cfg%0d cyc%0d got %b want %b", cur, n, o_valid, mq.size() != 0); end
      vectors++; if (o_count !== 3'(mq.size())) begin fails++; $display("FAIL rnd_count cfg%0d cyc%0d got %0d want %0d", cur, n, o_count, mq.size()); end
      vectors++; if (o_full !== (mq.size() == 4)) begin fails++; $display("FAIL rnd_full cfg%0d cyc%0d got %b want %b", cur, n, o_full, mq.size() == 4); end
      vectors++; if (o_empty !== (mq.size() == 0)) begin fails++; $display("FAIL rnd_empty cfg%0d cyc%0d got %b want %b", cur, n, o_empty, mq.size() == 0); end
    end
  endtask

  initial begin
    cur = 0; se = 1'b0; fl = 1'b0; rdy = 1'b0; din = '0;
    rst_n = 1'b1;
    #2;
    for (int c = 0; c < 3; c++) begin
      test_reset(c);
      test_basic_pack(c);
      test_flush(c);
      test_fill_backpressure(c);
    end
    test_push_pop(0);
    test_reset_mid(0);
    for (int c = 0; c < 3; c++) test_random(c);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
